stream_word_packer: RTL

//  Upstream feeder for the ping-pong async FIFO controller, entirely in the clk_in domain.
//  - Accepts narrow samples on a valid/ready stream and packs RATIO samples into one word.
//  - Emits each word as a single-cycle write strobe to the controller (data_in/data_in_en).
//  - Groups words into bursts of BURST_LEN and inserts GAP_CYC idle cycles after each burst.
//  - The gap gives the downstream push FSM time to swap FIFOs without dropping words.

---
 rtl/stream_pkg.sv | 24 ++
 rtl/stream_word_packer.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/stream_pkg.sv
// ---------------------------------------------------------------------------
// stream_pkg
//   Shared definitions for the stream_word_packer write-side feeder.
//   - state_t     : packer FSM states (pack samples / post-burst idle gap)
//   - lane_width  : width of a lane index for a given samples-per-word ratio
//   - OUT_W       : packed word width for the default sample width and ratio
// ---------------------------------------------------------------------------
package stream_pkg;

    typedef enum logic [0:0] {
        ST_PACK = 1'b0,
        ST_GAP  = 1'b1
    } state_t;

    localparam int IN_W_DEF  = 8;
    localparam int RATIO_DEF = 2;
    localparam int OUT_W     = IN_W_DEF * RATIO_DEF;

    // A lane index is always at least one bit, even for RATIO == 1.
    function automatic int lane_width(input int ratio);
        return (ratio > 1) ? $clog2(ratio) : 1;
    endfunction

endpackage

// File: rtl/stream_word_packer.sv
// ---------------------------------------------------------------------------
// stream_word_packer
//   Packs RATIO narrow samples (LSB lane first) into one word and emits it as
//   a single-cycle write strobe to the ping-pong async FIFO controller.
//   Words are grouped into bursts of BURST_LEN; after each burst (or frame
//   end) s_ready is held low so the downstream push FSM can swap FIFOs.
//
// Ports
//   clk_in      in   write-side clock
//   rst_n       in   asynchronous active-low reset
//   s_data      in   input sample (IN_W bits)
//   s_valid     in   sample valid
//   s_last      in   last sample of frame (qualified by s_valid && s_ready)
//   s_ready     out  sample accepted when s_valid && s_ready
//   hold        in   downstream pause; only gates s_ready
//   m_data      out  packed word (IN_W*RATIO bits) -> controller data_in
//   m_en        out  1-cycle write strobe -> controller data_in_en
//   burst_done  out  pulse with m_en of the last word of a burst/frame
//   frame_done  out  pulse with m_en of the word carrying s_last
//   words_sent  out  32-bit wrapping count of m_en strobes
//                    (present only when PACKER_WORD_CNT_EN is defined)
//
// Build option: `define PACKER_WORD_CNT_EN adds the words_sent counter/port.
// ---------------------------------------------------------------------------
module stream_word_packer
    import stream_pkg::*;
#(
    parameter int              IN_W      = IN_W_DEF,
    parameter int              RATIO     = RATIO_DEF,
    parameter int              BURST_LEN = 512,
    parameter int              GAP_CYC   = 4,
    parameter logic [IN_W-1:0] PAD_VAL   = '0
) (
    input  logic                  clk_in,
    input  logic                  rst_n,
    input  logic [IN_W-1:0]       s_data,
    input  logic                  s_valid,
    input  logic                  s_last,
    output logic                  s_ready,
    input  logic                  hold,
    output logic [IN_W*RATIO-1:0] m_data,
    output logic                  m_en,
    output logic                  burst_done,
`ifdef PACKER_WORD_CNT_EN
    output logic [31:0]           words_sent,
`endif
    output logic                  frame_done
);

    localparam int P_OUT_W = IN_W * RATIO;
    localparam int LANE_W  = lane_width(RATIO);
    localparam int WCNT_W  = $clog2(BURST_LEN + 1);
    localparam int GAP_W   = $clog2(GAP_CYC + 1);

    state_t              r_state;
    logic [LANE_W-1:0]   r_lane;
    logic [WCNT_W-1:0]   r_word_cnt;
    logic [GAP_W-1:0]    r_gap_cnt;
    logic [IN_W-1:0]     r_lanes [RATIO];
    logic [P_OUT_W-1:0]  r_m_data;
    logic                r_m_en;
    logic                r_burst_done;
    logic                r_frame_done;

    logic                w_ready;
    logic                w_accept;
    logic                w_word_done;
    logic                w_burst_end;
    logic [WCNT_W-1:0]   w_word_cnt_nxt;
    logic [P_OUT_W-1:0]  w_word;

    assign w_ready        = (r_state == ST_PACK) && !hold;
    assign w_accept       = s_valid && w_ready;
    assign w_word_done    = w_accept && (s_last || (r_lane == LANE_W'(RATIO - 1)));
    assign w_word_cnt_nxt = r_word_cnt + WCNT_W'(1);
    // A frame end that also fills the burst still yields just one gap.
    assign w_burst_end    = w_word_done && (s_last || (w_word_cnt_nxt == WCNT_W'(BURST_LEN)));

    // Completed word: stored lanes below the current one, the incoming sample
    // in the current lane, and PAD_VAL above it (only reachable on s_last).
    always_comb begin
        w_word = '0;
        for (int unsigned k = 0; k < RATIO; k++) begin
            if (LANE_W'(k) < r_lane) begin
                w_word[k*IN_W +: IN_W] = r_lanes[k];
            end else if (LANE_W'(k) == r_lane) begin
                w_word[k*IN_W +: IN_W] = s_data;
            end else begin
                w_word[k*IN_W +: IN_W] = PAD_VAL;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_PACK;
            r_lane       <= '0;
            r_word_cnt   <= '0;
            r_gap_cnt    <= '0;
            r_m_data     <= '0;
            r_m_en       <= 1'b0;
            r_burst_done <= 1'b0;
            r_frame_done <= 1'b0;
            for (int unsigned k = 0; k < RATIO; k++) begin
                r_lanes[k] <= '0;
            end
        end else begin
            r_m_en       <= w_word_done;
            r_burst_done <= w_burst_end;
            r_frame_done <= w_word_done && s_last;
            if (w_word_done) begin
                r_m_data <= w_word;
            end

            case (r_state)
                ST_PACK: begin
                    if (w_accept) begin
                        if (w_word_done) begin
                            r_lane <= '0;
                            if (w_burst_end) begin
                                r_word_cnt <= '0;
                                r_gap_cnt  <= '0;
                                r_state    <= ST_GAP;
                            end else begin
                                r_word_cnt <= w_word_cnt_nxt;
                            end
                        end else begin
                            r_lanes[r_lane] <= s_data;
                            r_lane          <= r_lane + LANE_W'(1);
                        end
                    end
                end
                ST_GAP: begin
                    // The m_en cycle of the final word is gap_cnt==0, so the
                    // GAP_CYC idle cycles follow it.
                    if (r_gap_cnt == GAP_W'(GAP_CYC)) begin
                        r_gap_cnt <= '0;
                        r_state   <= ST_PACK;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + GAP_W'(1);
                    end
                end
                default: r_state <= ST_PACK;
            endcase
        end
    end

`ifdef PACKER_WORD_CNT_EN
    logic [31:0] r_words_sent;

    // Advances on the same edge that raises m_en, so it tracks the strobe.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_words_sent <= '0;
        end else if (w_word_done) begin
            r_words_sent <= r_words_sent + 32'd1;
        end
    end

    assign words_sent = r_words_sent;
`endif

    assign s_ready    = w_ready;
    assign m_data     = r_m_data;
    assign m_en       = r_m_en;
    assign burst_done = r_burst_done;
    assign frame_done = r_frame_done;

endmodule
